inst_fetch_rom: RTL and testbench

Parametrised instruction ROM with an integrated fetch sequencer. It holds the program counter, reads the ROM synchronously, and presents one instruction at a time to the decoder over a valid/ready handshake. It supports start, jump redirect, address wrap-around and automatic halt on the fill word. It sits between the control unit (start/jump) and the decode stage, replacing the purely combinational address-to-instruction lookup.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/inst_rom_array.sv | 40 ++++
 rtl/inst_fetch_rom.sv | 117 +++++++++++
 tb/tb_inst_fetch_rom.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch ROM: sequencer states,
// default fill word and the ROM content function.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int unsigned MAX_W = 32;
  localparam logic [MAX_W-1:0] FILL_DEFAULT = {MAX_W{1'b1}};

  // Populated words hold their own address; everything above DEPTH reads as fill.
  function automatic logic [MAX_W-1:0] rom_word(
    input logic [MAX_W-1:0] addr,
    input logic [MAX_W-1:0] depth,
    input logic [MAX_W-1:0] fill
  );
    logic [MAX_W-1:0] word;
    if (addr < depth) begin
      word = addr;
    end else begin
      word = fill;
    end
    return word;
  endfunction

endpackage

// File: rtl/inst_rom_array.sv
// Synchronous-read instruction ROM; data_o updates on the edge where en_i is high.
module inst_rom_array import fetch_pkg::*; #(
  parameter int unsigned       ADDR_W = 8,
  parameter int unsigned       INST_W = 8,
  parameter int unsigned       DEPTH  = 5,
  parameter logic [INST_W-1:0] FILL   = FILL_DEFAULT[INST_W-1:0]
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [INST_W-1:0] data_o
);

  logic [MAX_W-1:0]  word_s;
  logic [INST_W-1:0] data_d;
  logic [INST_W-1:0] data_q;

  // Content lookup and read-enable hold.
  always_comb begin
    word_s = rom_word(MAX_W'(addr_i), MAX_W'(DEPTH), MAX_W'(FILL));
    if (en_i) begin
      data_d = word_s[INST_W-1:0];
    end else begin
      data_d = data_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= {INST_W{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/inst_fetch_rom.sv
// Instruction fetch sequencer: program counter, IDLE/RUN/HALT control and a
// valid/ready output stage in front of a synchronous-read instruction ROM.
module inst_fetch_rom import fetch_pkg::*; #(
  parameter int unsigned       ADDR_W = 8,
  parameter int unsigned       INST_W = 8,
  parameter int unsigned       DEPTH  = 5,
  parameter logic [INST_W-1:0] FILL   = FILL_DEFAULT[INST_W-1:0]
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o
);

  fetch_state_e      state_d, state_q;
  logic [ADDR_W-1:0] fetch_pc_d, fetch_pc_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              valid_d, valid_q;
  logic              busy_d, busy_q;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [INST_W-1:0] rom_data;

  // fetch_pc always names the next word to read; a start from IDLE/HALT reads
  // start_addr_i directly so the first word is valid one cycle later.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    rd_en      = 1'b0;
    rd_addr    = fetch_pc_q;
    case (state_q)
      IDLE, HALT: begin
        if (start_i) begin
          state_d    = RUN;
          rd_en      = 1'b1;
          rd_addr    = start_addr_i;
          pc_d       = start_addr_i;
          fetch_pc_d = start_addr_i + ADDR_W'(1'b1);
          valid_d    = 1'b1;
        end else begin
          valid_d    = 1'b0;
        end
      end
      RUN: begin
        if (jump_i) begin
          fetch_pc_d = jump_addr_i;
          valid_d    = 1'b0;
        end else if (start_i) begin
          fetch_pc_d = start_addr_i;
          valid_d    = 1'b0;
        end else if (valid_q && ready_i && (rom_data == FILL)) begin
          // Fill word just left for the decoder: stop without fetching more.
          state_d    = HALT;
          valid_d    = 1'b0;
        end else if (!valid_q || ready_i) begin
          rd_en      = 1'b1;
          rd_addr    = fetch_pc_q;
          pc_d       = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + ADDR_W'(1'b1);
          valid_d    = 1'b1;
        end else begin
          valid_d    = valid_q;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // Sequencer state, program counters and handshake flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= {ADDR_W{1'b0}};
      pc_q       <= {ADDR_W{1'b0}};
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  inst_rom_array #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .DEPTH  (DEPTH),
    .FILL   (FILL)
  ) u_rom (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (rd_en),
    .addr_i (rd_addr),
    .data_o (rom_data)
  );

  assign inst_o  = rom_data;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_inst_fetch_rom.sv
// Directed bench for inst_fetch_rom: vector table on the default build plus
// hand sequences for wrap-around, a wider parameter set and async reset.
module tb_inst_fetch_rom;

  logic clk;
  logic rst_ni;
  int   n_cmp;
  int   n_fail;

  // default build: ADDR_W=8, INST_W=8, DEPTH=5, FILL=0xFF
  logic       a_start, a_jump, a_ready, a_valid, a_busy;
  logic [7:0] a_sa, a_ja, a_inst, a_pc;
  // wrap build: ADDR_W=8, INST_W=16, DEPTH=256
  logic        b_start, b_ready, b_valid, b_busy;
  logic [7:0]  b_sa, b_pc;
  logic [15:0] b_inst;
  // sweep build: ADDR_W=10, INST_W=16, DEPTH=3
  logic        c_start, c_ready, c_valid, c_busy;
  logic [9:0]  c_sa, c_pc;
  logic [15:0] c_inst;
  logic        zero1;
  logic [7:0]  zero8;
  logic [9:0]  zero10;

  inst_fetch_rom u_a (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(a_start), .start_addr_i(a_sa),
    .jump_i(a_jump), .jump_addr_i(a_ja), .inst_o(a_inst), .pc_o(a_pc),
    .valid_o(a_valid), .ready_i(a_ready), .busy_o(a_busy)
  );

  inst_fetch_rom #(.ADDR_W(8), .INST_W(16), .DEPTH(256), .FILL(16'hFFFF)) u_b (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(b_start), .start_addr_i(b_sa),
    .jump_i(zero1), .jump_addr_i(zero8), .inst_o(b_inst), .pc_o(b_pc),
    .valid_o(b_valid), .ready_i(b_ready), .busy_o(b_busy)
  );

  inst_fetch_rom #(.ADDR_W(10), .INST_W(16), .DEPTH(3), .FILL(16'hFFFF)) u_c (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(c_start), .start_addr_i(c_sa),
    .jump_i(zero1), .jump_addr_i(zero10), .inst_o(c_inst), .pc_o(c_pc),
    .valid_o(c_valid), .ready_i(c_ready), .busy_o(c_busy)
  );

  typedef struct {
    logic       st;
    logic [7:0] sa;
    logic       jp;
    logic [7:0] ja;
    logic       rdy;
    logic       ev;
    logic       eb;
    logic [7:0] ei;
    logic [7:0] ep;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_ni = 1'b0;
    zero1 = 1'b0; zero8 = 8'h00; zero10 = 10'h000;
    a_start = 1'b0; a_sa = 8'h00; a_jump = 1'b0; a_ja = 8'h00; a_ready = 1'b0;
    b_start = 1'b0; b_sa = 8'h00; b_ready = 1'b0;
    c_start = 1'b0; c_sa = 10'h000; c_ready = 1'b0;

    //          st    sa     jp    ja     rdy   ev    eb    ei     ep
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 8'h02};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 8'h03};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 8'h04};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h05};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, 8'h02};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, 8'h02};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, 8'h02};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, 8'h02};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 8'h03};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 8'h02};
    vecs[16] = '{1'b1, 8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h04, 8'h04};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h04, 8'h04};
    vecs[19] = '{1'b1, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 8'h03};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 8'h04};
    vecs[22] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h05};
    vecs[23] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h05};
    vecs[24] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[25] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};

    repeat (2) @(negedge clk);
    chk("rst.inst",  32'(a_inst),  32'h0);
    chk("rst.pc",    32'(a_pc),    32'h0);
    chk("rst.valid", 32'(a_valid), 32'h0);
    chk("rst.busy",  32'(a_busy),  32'h0);
    rst_ni = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      a_start = vecs[i].st; a_sa = vecs[i].sa;
      a_jump  = vecs[i].jp; a_ja = vecs[i].ja;
      a_ready = vecs[i].rdy;
      step();
      chk($sformatf("v%0d.valid", i), 32'(a_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d.busy", i),  32'(a_busy),  32'(vecs[i].eb));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d.inst", i), 32'(a_inst), 32'(vecs[i].ei));
        chk($sformatf("v%0d.pc", i),   32'(a_pc),   32'(vecs[i].ep));
      end
    end
    a_start = 1'b0; a_jump = 1'b0; a_ready = 1'b0;

    // PC wrap-around with a word width that keeps 0xFF distinct from the fill word
    b_start = 1'b1; b_sa = 8'hFE; b_ready = 1'b1;
    step();
    b_start = 1'b0;
    chk("wrap0.valid", 32'(b_valid), 32'h1);
    chk("wrap0.inst",  32'(b_inst),  32'h00FE);
    chk("wrap0.pc",    32'(b_pc),    32'hFE);
    step();
    chk("wrap1.inst",  32'(b_inst),  32'h00FF);
    chk("wrap1.pc",    32'(b_pc),    32'hFF);
    step();
    chk("wrap2.valid", 32'(b_valid), 32'h1);
    chk("wrap2.inst",  32'(b_inst),  32'h0000);
    chk("wrap2.pc",    32'(b_pc),    32'h00);
    step();
    chk("wrap3.inst",  32'(b_inst),  32'h0001);
    chk("wrap3.pc",    32'(b_pc),    32'h01);
    b_ready = 1'b0;

    // Wider parameter set: three words, fill, then halt
    c_start = 1'b1; c_sa = 10'h000; c_ready = 1'b1;
    step();
    c_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sweep%0d.inst", k), 32'(c_inst), 32'(k));
      chk($sformatf("sweep%0d.pc", k),   32'(c_pc),   32'(k));
      step();
    end
    chk("sweep.fill.valid", 32'(c_valid), 32'h1);
    chk("sweep.fill.inst",  32'(c_inst),  32'hFFFF);
    chk("sweep.fill.pc",    32'(c_pc),    32'h003);
    step();
    chk("sweep.halt.valid", 32'(c_valid), 32'h0);
    chk("sweep.halt.busy",  32'(c_busy),  32'h0);
    step();
    chk("sweep.halt2.valid", 32'(c_valid), 32'h0);
    c_ready = 1'b0;

    // Asynchronous reset while a word is pending, then jump ignored in IDLE
    a_start = 1'b1; a_sa = 8'h03; a_ready = 1'b0;
    step();
    a_start = 1'b0;
    chk("pre_rst.valid", 32'(a_valid), 32'h1);
    chk("pre_rst.inst",  32'(a_inst),  32'h03);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst.inst",  32'(a_inst),  32'h0);
    chk("async_rst.pc",    32'(a_pc),    32'h0);
    chk("async_rst.valid", 32'(a_valid), 32'h0);
    chk("async_rst.busy",  32'(a_busy),  32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    a_jump = 1'b1; a_ja = 8'h02; a_ready = 1'b1;
    step();
    a_jump = 1'b0;
    chk("idle_jump.valid", 32'(a_valid), 32'h0);
    chk("idle_jump.busy",  32'(a_busy),  32'h0);
    step();
    chk("idle_jump2.valid", 32'(a_valid), 32'h0);
    a_start = 1'b1; a_sa = 8'h01;
    step();
    a_start = 1'b0;
    chk("restart.valid", 32'(a_valid), 32'h1);
    chk("restart.busy",  32'(a_busy),  32'h1);
    chk("restart.inst",  32'(a_inst),  32'h01);
    chk("restart.pc",    32'(a_pc),    32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
